// File: rtl/mpmc11_pkg.sv
// Shared types and constants for the mpmc11 memory controller.
package mpmc11_pkg;

    localparam int unsigned MEM_DATA_BITS = 128;
    localparam int unsigned LINE_STRIPS   = 4;

    typedef enum logic [2:0] {
        IDLE,
        ACTIVATE,
        WRITE_DATA,
        READ_CMD,
        READ_DATA0,
        READ_DATA1,
        PRECHARGE,
        REFRESH
    } mpmc11_state_t;

    typedef enum logic [1:0] {
        COL_IDLE,
        COL_ACTIVE,
        COL_HOLD
    } mpmc11_col_state_t;

    // Last strip index of a burst, clipped to what the line buffer can hold.
    function automatic logic [7:0] clamp_last(input logic [7:0] num, input logic [7:0] lim);
        return (num > lim) ? lim : num;
    endfunction

endpackage

// File: rtl/mpmc11_rd_line_collect.sv
// Assembles consecutive memory read strips into one line and holds it
// until the downstream consumer accepts it.
module mpmc11_rd_line_collect
    import mpmc11_pkg::*;
#(
    parameter int unsigned STRIP_BITS = MEM_DATA_BITS,
    parameter int unsigned MAX_STRIPS = LINE_STRIPS
) (
    input  logic                             clk,
    input  logic                             rst,
    input  mpmc11_state_t                    state,
    input  logic [7:0]                       num_strips,
    input  logic                             rd_data_valid,
    input  logic [STRIP_BITS-1:0]            rd_data,
    input  logic                             line_ready,
    output logic [STRIP_BITS*MAX_STRIPS-1:0] line_o,
    output logic                             line_valid,
    output logic [7:0]                       strip_cnt,
    output logic                             overrun
);

    localparam int unsigned LINE_BITS = STRIP_BITS * MAX_STRIPS;

    mpmc11_col_state_t      r_col;
    logic [LINE_BITS-1:0]   r_line;
    logic                   r_line_valid;
    logic [7:0]             r_strip_cnt;
    logic [7:0]             r_last;
    logic                   r_overrun;
    logic [7:0]             w_last;

    assign w_last = clamp_last(num_strips, 8'(MAX_STRIPS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col        <= COL_IDLE;
            r_line       <= '0;
            r_line_valid <= 1'b0;
            r_strip_cnt  <= 8'd0;
            r_last       <= 8'd0;
            r_overrun    <= 1'b0;
        end else begin
            case (r_col)
                COL_IDLE: begin
                    if (state == READ_DATA0) begin
                        r_col       <= COL_ACTIVE;
                        r_last      <= w_last;
                        r_line      <= '0;
                        r_strip_cnt <= 8'd0;
                        // A beat coinciding with the burst start lands in strip 0.
                        if (rd_data_valid) begin
                            r_line <= LINE_BITS'(rd_data);
                            if (w_last == 8'd0) begin
                                r_col        <= COL_HOLD;
                                r_line_valid <= 1'b1;
                            end else begin
                                r_strip_cnt <= 8'd1;
                            end
                        end
                    end else if (rd_data_valid) begin
                        r_overrun <= 1'b1;
                    end
                end
                COL_ACTIVE: begin
                    if (state == IDLE) begin
                        r_col       <= COL_IDLE;
                        r_strip_cnt <= 8'd0;
                    end else if (rd_data_valid) begin
                        for (int unsigned k = 0; k < MAX_STRIPS; k++) begin
                            if (r_strip_cnt == 8'(k))
                                r_line[k*STRIP_BITS +: STRIP_BITS] <= rd_data;
                        end
                        if (r_strip_cnt == r_last) begin
                            r_col        <= COL_HOLD;
                            r_line_valid <= 1'b1;
                        end else begin
                            r_strip_cnt <= r_strip_cnt + 8'd1;
                        end
                    end
                end
                COL_HOLD: begin
                    if (rd_data_valid)
                        r_overrun <= 1'b1;
                    if (line_ready) begin
                        r_col        <= COL_IDLE;
                        r_line_valid <= 1'b0;
                    end
                end
                default: begin
                    r_col        <= COL_IDLE;
                    r_line_valid <= 1'b0;
                end
            endcase
        end
    end

    assign line_o     = r_line;
    assign line_valid = r_line_valid;
    assign strip_cnt  = r_strip_cnt;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_mpmc11_rd_line_collect.sv
// Directed bench for the read line collector; a monitor checks each
// presented line against a queue of expected lines.
module tb_mpmc11_rd_line_collect;
    import mpmc11_pkg::*;

    localparam int unsigned SB = 128;
    localparam int unsigned NS = 4;
    localparam int unsigned LB = SB * NS;

    typedef struct {
        logic [LB-1:0] line;
        logic [7:0]    cnt;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    mpmc11_state_t state;
    logic [7:0]    num_strips;
    logic          rd_data_valid;
    logic [SB-1:0] rd_data;
    logic          line_ready;
    logic [LB-1:0] line_o;
    logic          line_valid;
    logic [7:0]    strip_cnt;
    logic          overrun;

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];

    mpmc11_rd_line_collect #(.STRIP_BITS(SB), .MAX_STRIPS(NS)) dut (
        .clk(clk), .rst(rst), .state(state), .num_strips(num_strips),
        .rd_data_valid(rd_data_valid), .rd_data(rd_data), .line_ready(line_ready),
        .line_o(line_o), .line_valid(line_valid), .strip_cnt(strip_cnt), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [SB-1:0] pat(input int n);
        return {16{8'(n)}};
    endfunction

    function automatic logic [LB-1:0] line4(input int d, input int c, input int b, input int a);
        return {pat(d), pat(c), pat(b), pat(a)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input int n);
        rd_data_valid = 1'b1;
        rd_data       = pat(n);
        tick();
        rd_data_valid = 1'b0;
    endtask

    task automatic start(input logic [7:0] ns);
        num_strips = ns;
        state      = READ_DATA0;
        tick();
        state      = READ_DATA1;
    endtask

    task automatic handshake();
        line_ready = 1'b1;
        tick();
        line_ready = 1'b0;
        chk("lv_drop_after_ready", LB'(line_valid), LB'(1'b0));
    endtask

    // Monitor: pop on each new line, then require the line to stay put while held.
    logic          prev_lv = 1'b0;
    logic [LB-1:0] held;
    always @(negedge clk) begin
        if (line_valid === 1'b1) begin
            if (!prev_lv) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_line: got %0h expected no line", line_o);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checks++;
                    if (line_o !== e.line || strip_cnt !== e.cnt) begin
                        errors++;
                        $display("FAIL line_content: got %0h cnt %0d expected %0h cnt %0d",
                                 line_o, strip_cnt, e.line, e.cnt);
                    end
                end
            end else begin
                chk("line_stable", line_o, held);
            end
            held = line_o;
        end
        prev_lv = (line_valid === 1'b1);
    end

    initial begin
        rst = 1'b1; state = IDLE; num_strips = 8'd0; rd_data_valid = 1'b0;
        rd_data = '0; line_ready = 1'b0;
        tick(); tick();
        chk("rst_line_valid", LB'(line_valid), '0);
        chk("rst_strip_cnt", LB'(strip_cnt), '0);
        chk("rst_overrun", LB'(overrun), '0);
        chk("rst_line_o", line_o, '0);
        rst = 1'b0;
        tick();

        // Back-to-back 4-beat burst.
        start(8'd3);
        exp_q.push_back('{line: line4(4, 3, 2, 1), cnt: 8'd3});
        beat(1); beat(2); beat(3);
        chk("b2b_no_lv_before_last", LB'(line_valid), '0);
        chk("b2b_cnt_before_last", LB'(strip_cnt), LB'(8'd3));
        beat(4);
        chk("b2b_lv_after_last", LB'(line_valid), LB'(1'b1));
        chk("b2b_strip_cnt", LB'(strip_cnt), LB'(8'd3));
        handshake();

        // Gapped beats, num_strips changed mid-burst, slow consumer.
        start(8'd3);
        exp_q.push_back('{line: line4(8'h44, 8'h33, 8'h22, 8'h11), cnt: 8'd3});
        beat(8'h11); num_strips = 8'd0; tick(); tick();
        beat(8'h22); tick(); tick();
        beat(8'h33); tick(); tick();
        chk("gap_no_lv_early", LB'(line_valid), '0);
        beat(8'h44);
        for (int i = 0; i < 5; i++) begin
            chk("gap_lv_held", LB'(line_valid), LB'(1'b1));
            tick();
        end
        chk("gap_lv_cycle6", LB'(line_valid), LB'(1'b1));
        handshake();
        chk("no_overrun_yet", LB'(overrun), '0);

        // num_strips beyond capacity clips to 4 beats; extra beat is an overrun.
        start(8'd9);
        exp_q.push_back('{line: line4(8'hd4, 8'hc3, 8'hb2, 8'ha1), cnt: 8'd3});
        beat(8'ha1); beat(8'hb2); beat(8'hc3); beat(8'hd4);
        chk("clip_lv", LB'(line_valid), LB'(1'b1));
        beat(8'he5);
        chk("clip_overrun", LB'(overrun), LB'(1'b1));
        chk("clip_line_unchanged", line_o, line4(8'hd4, 8'hc3, 8'hb2, 8'ha1));
        handshake();

        // Single-strip burst with the beat on the start cycle, right after a handshake.
        exp_q.push_back('{line: LB'(pat(8'h5a)), cnt: 8'd0});
        num_strips = 8'd0; state = READ_DATA0;
        rd_data_valid = 1'b1; rd_data = pat(8'h5a);
        tick();
        rd_data_valid = 1'b0; state = READ_DATA1;
        chk("single_lv", LB'(line_valid), LB'(1'b1));
        chk("single_cnt", LB'(strip_cnt), '0);
        handshake();

        // Abort after 2 beats, then a clean burst.
        start(8'd3);
        beat(8'h71); beat(8'h72);
        state = IDLE;
        tick();
        chk("abort_no_lv", LB'(line_valid), '0);
        chk("abort_cnt", LB'(strip_cnt), '0);
        tick();
        chk("abort_still_no_lv", LB'(line_valid), '0);
        start(8'd3);
        exp_q.push_back('{line: line4(8'h84, 8'h83, 8'h82, 8'h81), cnt: 8'd3});
        beat(8'h81); beat(8'h82); beat(8'h83); beat(8'h84);
        chk("clean_lv", LB'(line_valid), LB'(1'b1));
        // IDLE during hold must not disturb the held line.
        state = IDLE;
        tick();
        chk("hold_ignores_idle", LB'(line_valid), LB'(1'b1));
        handshake();

        // Reset during hold discards the line and clears the sticky overrun.
        start(8'd1);
        exp_q.push_back('{line: {pat(0), pat(0), pat(8'h92), pat(8'h91)}, cnt: 8'd1});
        beat(8'h91); beat(8'h92);
        chk("pre_rst_lv", LB'(line_valid), LB'(1'b1));
        chk("pre_rst_overrun", LB'(overrun), LB'(1'b1));
        rst = 1'b1; line_ready = 1'b0;
        tick();
        rst = 1'b0; state = IDLE;
        chk("hold_rst_lv", LB'(line_valid), '0);
        chk("hold_rst_line", line_o, '0);
        chk("hold_rst_overrun", LB'(overrun), '0);
        chk("hold_rst_cnt", LB'(strip_cnt), '0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_no_lv", LB'(line_valid), '0);
        end

        // Beat with no burst open sets overrun.
        beat(8'h33);
        chk("idle_beat_overrun", LB'(overrun), LB'(1'b1));
        chk("idle_beat_no_lv", LB'(line_valid), '0);

        tick();
        chk("queue_drained", LB'(exp_q.size()), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
